// File: rtl/fft_frame_arbiter.sv
// Two-requester frame arbiter in front of a shared streaming FFT core.
// Whole frames are granted and their results are routed back by a tag FIFO.
// Define FFT_ARB_FIXED_PRIO_EN to make channel 0 win every tie; otherwise ties alternate.
module fft_frame_arbiter #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned FRAME_LEN    = 16,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ch0_push,
  input  logic [WIDTH-1:0] ch0_real,
  input  logic [WIDTH-1:0] ch0_imag,
  output logic             ch0_stall,
  input  logic             ch1_push,
  input  logic [WIDTH-1:0] ch1_real,
  input  logic [WIDTH-1:0] ch1_imag,
  output logic             ch1_stall,
  output logic             fft_push,
  output logic [WIDTH-1:0] fft_real,
  output logic [WIDTH-1:0] fft_imag,
  input  logic             fft_stall,
  input  logic             fft_out_push,
  input  logic [WIDTH-1:0] fft_out_real,
  input  logic [WIDTH-1:0] fft_out_imag,
  output logic             fft_out_stall,
  output logic             out0_push,
  output logic [WIDTH-1:0] out0_real,
  output logic [WIDTH-1:0] out0_imag,
  input  logic             out0_stall,
  output logic             out1_push,
  output logic [WIDTH-1:0] out1_real,
  output logic [WIDTH-1:0] out1_imag,
  input  logic             out1_stall,
  output logic [2:0]       inflight
);

  localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_INFLIGHT - 1);
  localparam logic [2:0]       MAX_CNT   = 3'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_in_cnt;
  logic [CNT_W-1:0]        r_out_cnt;
  logic [MAX_INFLIGHT-1:0] r_tag_mem;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [2:0]              r_count;

  logic w_grant_valid;
  logic w_grant_ch;
  logic w_in_active;
  logic w_sel1;
  logic w_in_push;
  logic w_in_fire;
  logic w_tag_valid;
  logic w_tag_head;
  logic w_sel_stall;
  logic w_out_fire;
  logic w_pop;

  // Grant only from IDLE and only while the tag FIFO has room.
  assign w_grant_valid = (r_state == IDLE) && (r_count < MAX_CNT) && (ch0_push || ch1_push);

`ifdef FFT_ARB_FIXED_PRIO_EN
  assign w_grant_ch = ~ch0_push;
`else
  logic r_last_grant;

  // On a tie, grant whichever channel was not granted last.
  assign w_grant_ch = (ch0_push && ch1_push) ? ~r_last_grant : ch1_push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_grant_valid) begin
      r_last_grant <= w_grant_ch;
    end
  end
`endif

  // Input path: the granted channel is wired straight through to the core.
  assign w_in_active = (r_state != IDLE);
  assign w_sel1      = (r_state == GRANT1);
  assign w_in_push   = w_sel1 ? ch1_push : ch0_push;
  assign w_in_fire   = w_in_active && w_in_push && !fft_stall;

  assign fft_push  = w_in_active && w_in_push;
  assign fft_real  = w_sel1 ? ch1_real : ch0_real;
  assign fft_imag  = w_sel1 ? ch1_imag : ch0_imag;
  assign ch0_stall = (r_state == GRANT0) ? fft_stall : 1'b1;
  assign ch1_stall = (r_state == GRANT1) ? fft_stall : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_in_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_state <= w_grant_ch ? GRANT1 : GRANT0;
          end
        end
        GRANT0, GRANT1: begin
          if (w_in_fire) begin
            if (r_in_cnt == LAST_BEAT) begin
              r_state  <= IDLE;
              r_in_cnt <= '0;
            end else begin
              r_in_cnt <= r_in_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_in_cnt <= '0;
        end
      endcase
    end
  end

  // Output path: the oldest tag decides which requester receives core results.
  assign w_tag_valid = (r_count != 3'd0);
  assign w_tag_head  = r_tag_mem[r_rd_ptr];
  assign w_sel_stall = w_tag_head ? out1_stall : out0_stall;
  assign w_out_fire  = w_tag_valid && fft_out_push && !w_sel_stall;
  assign w_pop       = w_out_fire && (r_out_cnt == LAST_BEAT);

  assign fft_out_stall = !w_tag_valid || w_sel_stall;
  assign out0_push     = w_tag_valid && !w_tag_head && fft_out_push;
  assign out1_push     = w_tag_valid && w_tag_head && fft_out_push;
  assign out0_real     = fft_out_real;
  assign out0_imag     = fft_out_imag;
  assign out1_real     = fft_out_real;
  assign out1_imag     = fft_out_imag;
  assign inflight      = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_cnt <= '0;
    end else if (w_out_fire) begin
      r_out_cnt <= (r_out_cnt == LAST_BEAT) ? '0 : r_out_cnt + CNT_W'(1);
    end
  end

  // Tag FIFO: push on grant, pop on the last delivered beat of a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_mem <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= 3'd0;
    end else begin
      if (w_grant_valid) begin
        r_tag_mem[r_wr_ptr] <= w_grant_ch;
        r_wr_ptr            <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_grant_valid, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Bench for fft_frame_arbiter: randomized requesters and an identity FFT core model;
// each requester must get back exactly its own beats, in order.
module tb_fft_frame_arbiter;
  localparam int W  = 16;
  localparam int FL = 16;
  localparam int MI = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         ch0_push, ch0_stall, ch1_push, ch1_stall;
  logic [W-1:0] ch0_real, ch0_imag, ch1_real, ch1_imag;
  logic         fft_push, fft_stall, fft_out_push, fft_out_stall;
  logic [W-1:0] fft_real, fft_imag, fft_out_real, fft_out_imag;
  logic         out0_push, out0_stall, out1_push, out1_stall;
  logic [W-1:0] out0_real, out0_imag, out1_real, out1_imag;
  logic [2:0]   inflight;

  always #5 clk = ~clk;

  fft_frame_arbiter #(.WIDTH(W), .FRAME_LEN(FL), .MAX_INFLIGHT(MI)) dut (
    .clk(clk), .reset(reset),
    .ch0_push(ch0_push), .ch0_real(ch0_real), .ch0_imag(ch0_imag), .ch0_stall(ch0_stall),
    .ch1_push(ch1_push), .ch1_real(ch1_real), .ch1_imag(ch1_imag), .ch1_stall(ch1_stall),
    .fft_push(fft_push), .fft_real(fft_real), .fft_imag(fft_imag), .fft_stall(fft_stall),
    .fft_out_push(fft_out_push), .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag),
    .fft_out_stall(fft_out_stall),
    .out0_push(out0_push), .out0_real(out0_real), .out0_imag(out0_imag), .out0_stall(out0_stall),
    .out1_push(out1_push), .out1_real(out1_real), .out1_imag(out1_imag), .out1_stall(out1_stall),
    .inflight(inflight)
  );

  // Reference state: source queues, core contents, per-requester expected results.
  logic [31:0] src0[$], src1[$], core_q[$], exp0[$], exp1[$];
  int prob0, prob1, fst_prob, o0_prob, o1_prob, core_mode;
  bit fst_toggle;
  bit f0, f1, ffo;
  int in0_cnt, in1_cnt, in_tot, out0_cnt, out1_cnt, out_tot, mcyc;
  int start_ch[$], start_cyc[$], end_cyc[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: observes every transfer just before the rising edge that commits it.
  always @(negedge clk) begin
    logic c0f, c1f, ff, o0f, o1f, cof;
    logic [31:0] beat;
    int started, popped;
    bit ok;
    if (!reset) begin
      mcyc++;
      started = (in_tot + FL - 1) / FL;
      popped  = out_tot / FL;
      ok = (int'(inflight) >= started - popped) && (int'(inflight) <= started - popped + 1)
           && (int'(inflight) <= MI);
      chk("inflight_range", 32'(ok), 32'd1);
      c0f = ch0_push && !ch0_stall;
      c1f = ch1_push && !ch1_stall;
      ff  = fft_push && !fft_stall;
      chk("in_xfer", {30'd0, c0f && c1f, ff}, {30'd0, 1'b0, c0f || c1f});
      if (c0f || c1f) begin
        beat = c1f ? {ch1_real, ch1_imag} : {ch0_real, ch0_imag};
        chk("fft_data", {fft_real, fft_imag}, beat);
        if (in_tot % FL == 0) begin
          start_ch.push_back(c1f ? 1 : 0);
          start_cyc.push_back(mcyc);
        end
        if (in_tot % FL == FL - 1) end_cyc.push_back(mcyc);
        core_q.push_back(beat);
        in_tot++;
        if (c1f) begin exp1.push_back(beat); in1_cnt++; end
        else     begin exp0.push_back(beat); in0_cnt++; end
      end
      o0f = out0_push && !out0_stall;
      o1f = out1_push && !out1_stall;
      cof = fft_out_push && !fft_out_stall;
      chk("out_xfer", {30'd0, o0f && o1f, cof}, {30'd0, 1'b0, o0f || o1f});
      if (o0f) begin
        chk("out0_pending", 32'(exp0.size() > 0), 32'd1);
        if (exp0.size() > 0) chk("out0_data", {out0_real, out0_imag}, exp0.pop_front());
        out0_cnt++;
      end
      if (o1f) begin
        chk("out1_pending", 32'(exp1.size() > 0), 32'd1);
        if (exp1.size() > 0) chk("out1_data", {out1_real, out1_imag}, exp1.pop_front());
        out1_cnt++;
      end
      if (cof) out_tot++;
      f0 = c0f; f1 = c1f; ffo = cof;
    end
  end

  function automatic bit roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic drive();
    if (f0 && src0.size() > 0) void'(src0.pop_front());
    if (f1 && src1.size() > 0) void'(src1.pop_front());
    if (ffo && core_q.size() > 0) void'(core_q.pop_front());
    f0 = 0; f1 = 0; ffo = 0;
    ch0_push = (src0.size() > 0) && roll(prob0);
    {ch0_real, ch0_imag} = (src0.size() > 0) ? src0[0] : 32'd0;
    ch1_push = (src1.size() > 0) && roll(prob1);
    {ch1_real, ch1_imag} = (src1.size() > 0) ? src1[0] : 32'd0;
    fft_stall = fst_toggle ? ~fft_stall : roll(fst_prob);
    fft_out_push = (core_q.size() > 0) && ((core_mode == 2) || (core_mode == 1 && roll(60)));
    {fft_out_real, fft_out_imag} = (core_q.size() > 0) ? core_q[0] : 32'd0;
    out0_stall = roll(o0_prob);
    out1_stall = roll(o1_prob);
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive();
    @(negedge clk); #1;
  endtask

  task automatic load(input int ch, input int frames, input bit impulse);
    for (int i = 0; i < frames * FL; i++) begin
      logic [31:0] b;
      b = impulse ? ((i == 0) ? 32'h7fff_0000 : 32'd0) : $urandom;
      if (ch == 0) src0.push_back(b); else src1.push_back(b);
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    reset = 1'b1;
    src0.delete(); src1.delete(); core_q.delete(); exp0.delete(); exp1.delete();
    start_ch.delete(); start_cyc.delete(); end_cyc.delete();
    f0 = 0; f1 = 0; ffo = 0;
    in0_cnt = 0; in1_cnt = 0; in_tot = 0; out0_cnt = 0; out1_cnt = 0; out_tot = 0;
    prob0 = 0; prob1 = 0; fst_prob = 0; o0_prob = 0; o1_prob = 0; core_mode = 0; fst_toggle = 0;
    ch0_push = 1'b1; ch1_push = 1'b1; fft_stall = 1'b0; fft_out_push = 1'b1;
    out0_stall = 1'b0; out1_stall = 1'b0;
    @(negedge clk); #1;
    chk({tag, "_fft_push"}, 32'(fft_push), 32'd0);
    chk({tag, "_inflight"}, 32'(inflight), 32'd0);
    chk({tag, "_ch_stall"}, {30'd0, ch1_stall, ch0_stall}, 32'd3);
    chk({tag, "_out_push"}, {30'd0, out1_push, out0_push}, 32'd0);
    chk({tag, "_fft_out_stall"}, 32'(fft_out_stall), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    ch0_push = 1'b0; ch1_push = 1'b0; fft_out_push = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while ((src0.size() + src1.size() + core_q.size() + exp0.size() + exp1.size()) > 0 && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 32'(n < bound), 32'd1);
    step();
    chk({tag, "_inflight_zero"}, 32'(inflight), 32'd0);
  endtask

  initial begin
    int first, last, nb, req_cyc, k;
    int exp_order[4];
    reset = 1'b1;
    ch0_push = 0; ch1_push = 0; ch0_real = 0; ch0_imag = 0; ch1_real = 0; ch1_imag = 0;
    fft_stall = 0; fft_out_push = 0; fft_out_real = 0; fft_out_imag = 0;
    out0_stall = 0; out1_stall = 0;
    mcyc = 0;

    // Single ch0 impulse frame, no stalls.
    do_reset("rst_a");
    load(0, 1, 1'b1);
    prob0 = 100;
    first = -1; last = -1; nb = 0;
    req_cyc = mcyc + 1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("a_ch1_stall", 32'(ch1_stall), 32'd1);
      if (f0) begin
        if (first < 0) first = mcyc;
        last = mcyc;
        nb++;
      end
    end
    chk("a_beats", nb, 16);
    chk("a_latency", first - req_cyc, 1);
    chk("a_consecutive", last - first, 15);
    chk("a_inflight_one", 32'(inflight), 32'd1);
    chk("a_no_out_yet", out0_cnt + out1_cnt, 0);
    core_mode = 1;
    wait_idle("a", 400);
    chk("a_out0_beats", out0_cnt, 16);
    chk("a_out1_beats", out1_cnt, 0);

    // Both channels requesting continuously.
    do_reset("rst_b");
    load(0, 4, 1'b0);
    load(1, 4, 1'b0);
    prob0 = 100; prob1 = 100; core_mode = 2;
    k = 0;
    while ((start_ch.size() < 4 || end_cyc.size() < 4) && k < 300) begin step(); k++; end
    chk("b_frames_seen", 32'(start_ch.size() >= 4 && end_cyc.size() >= 4), 32'd1);
`ifdef FFT_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    if (start_ch.size() >= 4 && end_cyc.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("b_grant%0d", i), start_ch[i], exp_order[i]);
      for (int i = 0; i < 3; i++) chk($sformatf("b_gap%0d", i), start_cyc[i+1] - end_cyc[i], 2);
    end
    wait_idle("b", 1000);

    // ch1 frame with fft_stall toggling every cycle.
    do_reset("rst_c");
    load(1, 1, 1'b0);
    prob1 = 100; fst_toggle = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (in1_cnt >= 1 && in1_cnt < 16) chk("c_stall_mirror", 32'(ch1_stall), 32'(fft_stall));
      chk("c_ch0_stall", 32'(ch0_stall), 32'd1);
    end
    chk("c_in_beats", in1_cnt, 16);
    chk("c_in0_beats", in0_cnt, 0);
    fst_toggle = 0; core_mode = 1;
    wait_idle("c", 400);
    chk("c_out1_beats", out1_cnt, 16);

    // Results stalled: inflight saturates and blocks further grants.
    do_reset("rst_d");
    load(0, 6, 1'b0);
    prob0 = 100; o0_prob = 100; core_mode = 1;
    for (int i = 0; i < 150; i++) step();
    chk("d_inflight_full", 32'(inflight), 32'd4);
    chk("d_in_beats", in0_cnt, 64);
    chk("d_no_grant", {30'd0, ch1_stall, ch0_stall}, 32'd3);
    chk("d_out_held", out0_cnt, 0);
    o0_prob = 0;
    wait_idle("d", 2000);
    chk("d_total_in", in0_cnt, 96);
    chk("d_total_out", out0_cnt, 96);

    // Reset in the middle of a ch0 frame, then a fresh frame.
    do_reset("rst_e0");
    load(0, 2, 1'b0);
    prob0 = 100;
    k = 0;
    while (in0_cnt < 7 && k < 40) begin step(); k++; end
    chk("e_seven_beats", in0_cnt, 7);
    do_reset("e_cut");
    load(0, 1, 1'b0);
    prob0 = 100; core_mode = 1;
    wait_idle("e", 400);
    chk("e_in_beats", in0_cnt, 16);
    chk("e_out_beats", out0_cnt, 16);

    // Last output beat of a frame on the same edge as a new grant.
    do_reset("rst_f");
    load(0, 3, 1'b0);
    prob0 = 100; o0_prob = 100; core_mode = 1;
    for (int i = 0; i < 80; i++) step();
    chk("f_inflight_three", 32'(inflight), 32'd3);
    o0_prob = 0; core_mode = 2;
    k = 0;
    while (out0_cnt < 15 && k < 100) begin step(); k++; end
    core_mode = 0;
    for (int i = 0; i < 3; i++) step();
    chk("f_out_15", out0_cnt, 15);
    chk("f_pre_inflight", 32'(inflight), 32'd3);
    load(1, 1, 1'b0);
    prob1 = 100; core_mode = 2;
    step();
    chk("f_pop_beat", out0_cnt, 16);
    chk("f_req", 32'(ch1_push), 32'd1);
    core_mode = 0;
    step();
    chk("f_inflight_hold", 32'(inflight), 32'd3);
    chk("f_granted", 32'(ch1_stall), 32'd0);
    core_mode = 1;
    wait_idle("f", 1000);
    chk("f_out0_total", out0_cnt, 48);
    chk("f_out1_total", out1_cnt, 16);

    // Randomized traffic on every link.
    for (int it = 0; it < 3; it++) begin
      int n0, n1;
      do_reset("rst_g");
      n0 = int'($urandom_range(5, 2));
      n1 = int'($urandom_range(5, 2));
      load(0, n0, 1'b0);
      load(1, n1, 1'b0);
      prob0 = int'($urandom_range(100, 40)); prob1 = int'($urandom_range(100, 40));
      fst_prob = int'($urandom_range(40, 0));
      o0_prob = int'($urandom_range(40, 0)); o1_prob = int'($urandom_range(40, 0));
      core_mode = 1;
      wait_idle("g", 6000);
      chk("g_in0", in0_cnt, n0 * FL);
      chk("g_in1", in1_cnt, n1 * FL);
      chk("g_out0", out0_cnt, n0 * FL);
      chk("g_out1", out1_cnt, n1 * FL);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
